// File: rtl/mux_scan_n.sv
// mux_scan_n
//
// Registered N:1 channel multiplexer with two modes. In manual mode the
// channel is picked by sel_i. In auto-scan mode the block visits every
// channel in turn and stays on each one for DWELL cycles. It feeds
// time-shared consumers such as one display driver or one serial output
// stage that has to read several sources in turn.
//
// Parameters
//   N      channel count (2..16)
//   W      data width per channel (1..32)
//   DWELL  cycles spent on each channel in scan mode (1..255)
//   SELW   derived select width, clog2(N) with a minimum of 1
//
// Ports
//   clk_i    clock, all state changes on the rising edge
//   rst_i    asynchronous active-high reset
//   en_i     global enable; when low every register holds and wrap_o drops
//   mode_i   0 = manual select, 1 = auto scan
//   hold_i   scan mode only: freezes channel advance and dwell count
//   sel_i    channel select used in manual mode
//   a_i      packed channel data, channel k is a_i[k*W +: W]
//   y_o      registered data of the selected channel
//   ch_o     channel currently driving y_o
//   valid_o  y_o holds legal channel data
//   wrap_o   one-cycle strobe when the scan goes from channel N-1 to 0
module mux_scan_n #(
    parameter int N     = 5,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int SELW = (N < 2) ? 1 : $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              mode_i,
    input  logic              hold_i,
    input  logic [SELW-1:0]   sel_i,
    input  logic [N*W-1:0]    a_i,
    output logic [W-1:0]      y_o,
    output logic [SELW-1:0]   ch_o,
    output logic              valid_o,
    output logic              wrap_o
);

    localparam int CW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);

    localparam logic [SELW-1:0] CH_LAST    = SELW'(N - 1);
    localparam logic [SELW:0]   CH_COUNT   = (SELW + 1)'(N);
    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    y_q, y_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            sel_in_range_s;
    logic            ch_in_range_s;

    // Returns the data of channel idx; out-of-range indices give zero.
    function automatic logic [W-1:0] chan_data(input logic [N*W-1:0] bus,
                                               input logic [SELW-1:0] idx);
        logic [W-1:0] res;
        res = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) begin
                res = bus[k*W +: W];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Range checks are done one bit wider so that N = 2**SELW still compares correctly.
    assign sel_in_range_s = ({1'b0, sel_i} < CH_COUNT);
    assign ch_in_range_s  = ({1'b0, ch_q}  < CH_COUNT);

    // Next-state and next-output logic for the mode FSM and the scan datapath.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        if (en_i) begin
            case (state_q)
                ST_IDLE, ST_MANUAL, ST_SCAN: begin
                    if (!mode_i) begin
                        // Manual: follow sel, blank the output on an illegal select.
                        state_d = ST_MANUAL;
                        ch_d    = sel_i;
                        cnt_d   = '0;
                        if (sel_in_range_s) begin
                            y_d     = chan_data(a_i, sel_i);
                            valid_d = 1'b1;
                        end else begin
                            y_d     = '0;
                            valid_d = 1'b0;
                        end
                    end else if (state_q != ST_SCAN) begin
                        // Scan entry: start on the current channel (or 0 if it is
                        // illegal) with a fresh dwell; this is not a wrap.
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                        if (ch_in_range_s) begin
                            ch_d = ch_q;
                        end else begin
                            ch_d = '0;
                        end
                        y_d     = chan_data(a_i, ch_d);
                        valid_d = 1'b1;
                    end else begin
                        // Running scan: count dwell, advance channel mod N.
                        state_d = ST_SCAN;
                        valid_d = 1'b1;
                        if (hold_i) begin
                            cnt_d = cnt_q;
                            ch_d  = ch_q;
                        end else if (cnt_q == DWELL_LAST) begin
                            cnt_d = '0;
                            if (ch_q == CH_LAST) begin
                                ch_d   = '0;
                                wrap_d = 1'b1;
                            end else begin
                                ch_d = ch_q + SELW'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                        // y is loaded from the channel that ch will show after this edge.
                        y_d = chan_data(a_i, ch_d);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output and dwell-counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y_o     = y_q;
    assign ch_o    = ch_q;
    assign valid_o = valid_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n configured as N=5, W=4, DWELL=3.
// Channel k of the default input pattern carries 4'hA + k.
module tb_mux_scan_n;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic        hold;
    logic [2:0]  sel;
    logic [19:0] a;
    logic [3:0]  y;
    logic [2:0]  ch;
    logic        valid;
    logic        wrap;

    int vecs;
    int errs;

    mux_scan_n #(.N(5), .W(4), .DWELL(3)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .mode_i  (mode),
        .hold_i  (hold),
        .sel_i   (sel),
        .a_i     (a),
        .y_o     (y),
        .ch_o    (ch),
        .valid_o (valid),
        .wrap_o  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] ey, input logic [2:0] ech,
                             input logic ev, input logic ew);
        chk($sformatf("%s.y", tag),     32'(y),     32'(ey));
        chk($sformatf("%s.ch", tag),    32'(ch),    32'(ech));
        chk($sformatf("%s.valid", tag), 32'(valid), 32'(ev));
        chk($sformatf("%s.wrap", tag),  32'(wrap),  32'(ew));
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] ech;
        vecs = 0;
        errs = 0;
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        hold = 1'b0;
        sel  = 3'd0;
        a    = 20'h00000;

        // Reset held while a changes.
        for (int i = 0; i < 3; i++) begin
            a = 20'(($urandom & 32'h000FFFFF));
            step();
            check_out($sformatf("rst%0d", i), 4'h0, 3'd0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        a   = 20'hEDCBA;
        sel = 3'd3;
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("idle%0d", i), 4'h0, 3'd0, 1'b0, 1'b0);
        end

        // Manual sweep.
        en   = 1'b1;
        mode = 1'b0;
        for (int s = 0; s < 5; s++) begin
            sel = 3'(s);
            step();
            check_out($sformatf("man%0d", s), 4'hA + 4'(s), 3'(s), 1'b1, 1'b0);
        end
        sel = 3'd6;
        step();
        check_out("man_oor", 4'h0, 3'd6, 1'b0, 1'b0);

        // Scan with wrap, starting at channel 0.
        sel = 3'd0;
        step();
        check_out("man_ch0", 4'hA, 3'd0, 1'b1, 1'b0);
        mode = 1'b1;
        for (int i = 0; i <= 22; i++) begin
            step();
            ech = 3'((i / 3) % 5);
            check_out($sformatf("scan%0d", i), 4'hA + 4'(ech), ech, 1'b1, (i == 15));
        end

        // Hold mid-dwell on channel 2 (counter at 1) while a[2] changes.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a[11:8] = 4'h5 + 4'(i);
            step();
            check_out($sformatf("hold%0d", i), 4'h5 + 4'(i), 3'd2, 1'b1, 1'b0);
        end
        hold    = 1'b0;
        a[11:8] = 4'hC;
        step();
        check_out("hold_rest", 4'hC, 3'd2, 1'b1, 1'b0);
        step();
        check_out("hold_adv", 4'hD, 3'd3, 1'b1, 1'b0);

        // Enable low: everything frozen even though a changes.
        en = 1'b0;
        a  = 20'h12345;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("en_off%0d", i), 4'hD, 3'd3, 1'b1, 1'b0);
        end
        en = 1'b1;
        a  = 20'hEDCBA;
        step();
        check_out("en_on0", 4'hD, 3'd3, 1'b1, 1'b0);
        step();
        check_out("en_on1", 4'hD, 3'd3, 1'b1, 1'b0);

        // Scan -> manual at ch 3 with sel=1.
        mode = 1'b0;
        sel  = 3'd1;
        step();
        check_out("to_man", 4'hB, 3'd1, 1'b1, 1'b0);

        // Manual -> scan resumes at ch 1 with a full dwell.
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            ech = (i < 3) ? 3'd1 : 3'd2;
            check_out($sformatf("resume%0d", i), 4'hA + 4'(ech), ech, 1'b1, 1'b0);
        end

        // Illegal manual select, then scan entry must start at 0 without wrap.
        mode = 1'b0;
        sel  = 3'd7;
        step();
        check_out("man_sel7", 4'h0, 3'd7, 1'b0, 1'b0);
        mode = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            step();
            ech = 3'(k / 3);
            check_out($sformatf("entry%0d", k), 4'hA + 4'(ech), ech, 1'b1, 1'b0);
        end

        // Now at ch 4 with counter 1: asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 4'h0, 3'd0, 1'b0, 1'b0);
        step();
        check_out("rst_held", 4'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            ech = (i < 3) ? 3'd0 : 3'd1;
            check_out($sformatf("post_rst%0d", i), 4'hA + 4'(ech), ech, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
